// File: rtl/flash_addr_gen_if.sv
// flash_addr_gen bus: control strobes and byte from the bridge FSM,
// plus the registered flash address and status outputs.
interface flash_addr_gen_if #(
  parameter int ADDR_W = 16,
  parameter int BC_W   = 7
);
  logic [7:0]        ShiftRegOut;
  logic              LoadByte;
  logic              ClrLoad;
  logic              IncrAddr;
  logic [2:0]        SelMode;
  logic [ADDR_W-1:0] Addr;
  logic              AddrValid;
  logic [BC_W-1:0]   BurstCnt;
  logic              BurstFull;
  logic              PageWrap;
  logic              LoadErr;

  modport master (
    output ShiftRegOut, LoadByte, ClrLoad, IncrAddr, SelMode,
    input  Addr, AddrValid, BurstCnt, BurstFull, PageWrap, LoadErr
  );

  modport slave (
    input  ShiftRegOut, LoadByte, ClrLoad, IncrAddr, SelMode,
    output Addr, AddrValid, BurstCnt, BurstFull, PageWrap, LoadErr
  );
endinterface

// File: rtl/flash_addr_gen.sv
// Flash address generator: MSB-first byte assembly, page-bounded
// auto-increment with burst limit, and unlock-address output mux.
// Ports: SCL (state on falling edge), Reset (sync, active high),
// bus (slave side of flash_addr_gen_if).
module flash_addr_gen #(
  parameter int                ADDR_W    = 16,
  parameter int                PAGE_W    = 6,
  parameter int                BURST_MAX = 64,
  parameter logic [ADDR_W-1:0] UNLOCK1   = 'h5555,
  parameter logic [ADDR_W-1:0] UNLOCK2   = 'h2AAA
) (
  input  logic            SCL,
  input  logic            Reset,
  flash_addr_gen_if.slave bus
);
  localparam int NB   = ADDR_W / 8;
  localparam int PW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int BC_W = $clog2(BURST_MAX) + 1;

  localparam logic [PW-1:0]   LAST_PTR = PW'(NB - 1);
  localparam logic [BC_W-1:0] BMAX     = BC_W'(BURST_MAX);

  logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     byte_ptr_q, byte_ptr_d;
  logic              valid_q, valid_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              burst_full;

  assign burst_full = (burst_q == BMAX);

  always_comb begin
    addr_reg_d = addr_reg_q;
    addr_d     = addr_q;
    byte_ptr_d = byte_ptr_q;
    valid_d    = valid_q;
    burst_d    = burst_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;

    // Output mux samples AddrReg as it stood before this edge.
    case (bus.SelMode)
      3'd0:    addr_d = addr_reg_q;
      3'd1:    addr_d = UNLOCK1;
      3'd2:    addr_d = UNLOCK2;
      default: addr_d = addr_q;
    endcase

    if (bus.ClrLoad) begin
      byte_ptr_d = '0;
      valid_d    = 1'b0;
      burst_d    = '0;
    end else if (bus.LoadByte) begin
      if (valid_q) begin
        err_d = 1'b1;
      end else begin
        // Slot NB-1-ptr: first byte lands in the MSB.
        for (int i = 0; i < NB; i++) begin
          if (byte_ptr_q == PW'(NB - 1 - i))
            addr_reg_d[8*i +: 8] = bus.ShiftRegOut;
        end
        if (byte_ptr_q == LAST_PTR) begin
          byte_ptr_d = '0;
          valid_d    = 1'b1;
          burst_d    = '0;
        end else begin
          byte_ptr_d = byte_ptr_q + 1'b1;
        end
      end
    end else if (bus.IncrAddr) begin
      if (!valid_q || burst_full) begin
        err_d = 1'b1;
      end else begin
        addr_reg_d[PAGE_W-1:0] = addr_reg_q[PAGE_W-1:0] + 1'b1;
        burst_d                = burst_q + 1'b1;
        wrap_d                 = &addr_reg_q[PAGE_W-1:0];
      end
    end
  end

  always_ff @(negedge SCL) begin
    if (Reset) begin
      addr_reg_q <= '0;
      addr_q     <= '0;
      byte_ptr_q <= '0;
      valid_q    <= 1'b0;
      burst_q    <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_reg_q <= addr_reg_d;
      addr_q     <= addr_d;
      byte_ptr_q <= byte_ptr_d;
      valid_q    <= valid_d;
      burst_q    <= burst_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign bus.Addr      = addr_q;
  assign bus.AddrValid = valid_q;
  assign bus.BurstCnt  = burst_q;
  assign bus.BurstFull = burst_full;
  assign bus.PageWrap  = wrap_q;
  assign bus.LoadErr   = err_q;
endmodule

// File: doc/flash_addr_gen.md
# flash_addr_gen

Parametrised flash address generator for the I2C-to-flash bridge, the successor to the fixed 16-bit address register. Assembles an ADDR_W-bit byte address from successive I2C data bytes (MSB first) and performs page-bounded auto-increment for sequential reads and page writes. Counts burst length against a programmable limit, and drives either the assembled address or the two flash unlock-sequence addresses onto the flash address bus. It sits between the I2C shift register and the flash interface, and is controlled by the bridge's protocol state machine.

## Interface
Parameters:
- ADDR_W, 16, address width in bits; multiple of 8, range 8..32
- PAGE_W, 6, log2 of page size in bytes; 1 <= PAGE_W < ADDR_W
- BURST_MAX, 64, maximum accepted increments per burst; 1..2^PAGE_W
- UNLOCK1, 'h5555, first unlock-cycle address (ADDR_W bits)
- UNLOCK2, 'h2AAA, second unlock-cycle address (ADDR_W bits)

Ports:
- SCL  in  1  clock; all state updates on the falling edge
- Reset  in  1  synchronous, active-high reset
- ShiftRegOut  in  8  received I2C byte
- LoadByte  in  1  load ShiftRegOut into the next address byte slot
- ClrLoad  in  1  restart address assembly and clear the burst count
- IncrAddr  in  1  advance the address by one within the page
- SelMode  in  3  output select: 0 ADDR, 1 UNLOCK1, 2 UNLOCK2, 3 HOLD, 4..7 treated as HOLD
- Addr  out  ADDR_W  registered flash address
- AddrValid  out  1  all ADDR_W/8 bytes have been loaded
- BurstCnt  out  log2(BURST_MAX)+1  accepted increments since the last ClrLoad or completed load
- BurstFull  out  1  BurstCnt == BURST_MAX
- PageWrap  out  1  one-cycle pulse when an increment wraps the page
- LoadErr  out  1  one-cycle pulse on a rejected LoadByte or IncrAddr

## Operation
- Internal state:
  - AddrReg (ADDR_W bits)
  - BytePtr (0..NB-1, where NB = ADDR_W/8)
  - AddrValid
  - BurstCnt
- Control priority per edge: Reset > ClrLoad > LoadByte > IncrAddr. A lower-priority request asserted in the same cycle as a higher one is dropped silently, with no LoadErr.
- ClrLoad: BytePtr=0, AddrValid=0, BurstCnt=0. AddrReg is retained.
- LoadByte with AddrValid=0:
  - AddrReg byte (NB-1-BytePtr) <= ShiftRegOut, so the first byte received lands in the MSB.
  - BytePtr increments.
  - On the NB-th byte: AddrValid=1, BytePtr=0, BurstCnt=0.
- LoadByte with AddrValid=1: AddrReg is unchanged and LoadErr pulses.
- IncrAddr with AddrValid=1 and BurstFull=0:
  - AddrReg[PAGE_W-1:0] increments modulo 2^PAGE_W; the upper bits never change.
  - BurstCnt increments.
  - PageWrap pulses if the low field was all ones before the increment.
- IncrAddr with AddrValid=0 or BurstFull=1: no change, LoadErr pulses.
- BurstFull is combinational from BurstCnt.
- Output mux, registered each edge:
  - ADDR: Addr <= AddrReg as it stood before this edge.
  - UNLOCK1: Addr <= UNLOCK1.
  - UNLOCK2: Addr <= UNLOCK2.
  - HOLD: Addr keeps its value.
  - Addr never carries X.

## Timing
- Reset values: Addr=0, AddrReg=0, BytePtr=0, AddrValid=0, BurstCnt=0, BurstFull=0, PageWrap=0, LoadErr=0.
- Reset asserted mid-assembly or mid-burst discards all partial state on that edge.
- Internal latency: LoadByte or IncrAddr at edge n updates AddrReg at edge n. AddrValid, BurstCnt, PageWrap and LoadErr are valid after edge n.
- Addr latency: in ADDR mode, Addr reflects the edge-n update after edge n+1 (one-edge output latency).
- A mode change at edge n takes effect on Addr at edge n.
- PageWrap and LoadErr are high for exactly one SCL period, and are 0 on any edge without a triggering event.
- Back-to-back operations are supported: one LoadByte or IncrAddr per edge, with no idle cycles required.

## Test plan
All scenarios use ADDR_W=16, PAGE_W=6, BURST_MAX=64.
- Reset, then LoadByte 'h12 followed by 'h34, SelMode=0:
  - AddrValid rises after the second edge.
  - Addr='h1234 one edge later.
  - A third LoadByte leaves Addr='h1234 and pulses LoadErr.
- Load 'h123E, then 3× IncrAddr:
  - AddrReg goes 'h123F, 'h1200, 'h1201.
  - PageWrap pulses only on the 'h123F->'h1200 edge.
  - BurstCnt=3.
- Load 'h0000, then 70× IncrAddr:
  - BurstCnt saturates at 64 and BurstFull=1.
  - Increments 65..70 pulse LoadErr; AddrReg='h0000 after the wrap.
  - ClrLoad clears BurstCnt to 0 and AddrValid to 0.
- SelMode sequence 1, 2, 3, 0 with AddrReg='hBEEF:
  - Addr goes 'h5555, 'h2AAA, 'h2AAA (hold), 'hBEEF.
- Simultaneous events:
  - LoadByte+IncrAddr in the same cycle: the byte is loaded, no increment, no LoadErr.
  - ClrLoad+LoadByte in the same cycle: BytePtr=0, byte not stored.
- Reset asserted after one of two address bytes: all outputs return to reset values. A subsequent two-byte load of 'hA5C3 yields Addr='hA5C3.
